load_4bit_down_timer: RTL
=========================

# load_4bit_down_timer

Loadable, pausable down-counting timer with start/done handshake. It is the consuming-direction counterpart of the team's loadable up-counter. A controller loads a preset and pulses `start`. The block decrements once per clock while running and signals expiry with a single-cycle `done` pulse. It sits beside the up-counter in the lab counter set and serves as a programmable delay/timeout source.

## Interface
- `WIDTH`, default 4: width of preset and count.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  preset strobe; samples `data_in` into both the count and the reload register.
- `data_in`  in  WIDTH  preset value.
- `start`  in  1  start request, level-sampled each edge.
- `pause`  in  1  freezes the count while in RUN.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high while the state is RUN.
- `done`  out  1  one-cycle expiry pulse, registered.
- `zero`  out  1  high when `count == 0`; decoded from the `count` register.

## Operation
- **Internal state:**
  - `rld` reload register, WIDTH bits.
  - FSM with states IDLE, RUN, EXPIRED.
- **Reset** (`reset` low, asynchronous, overrides everything): `count=0`, `rld=0`, state IDLE, `busy=0`, `done=0`, `zero=1`.
- **Default:** `done` is 0 every cycle unless a rule below sets it.
- **Priority at each edge:** `load` > state behaviour.
- **`load`=1, any state:**
  - `count<=data_in`, `rld<=data_in`.
  - Next state IDLE, `done<=0`.
  - A `start` in the same cycle is ignored.
- **IDLE:**
  - `start`=1 and `count!=0`: go to RUN; `count` unchanged this edge.
  - `start`=1 and `count==0`: `done<=1`, go to EXPIRED.
  - Otherwise hold.
- **RUN:**
  - `pause`=1: hold `count` and state.
  - `pause`=0 and `count>1`: `count<=count-1`.
  - `pause`=0 and `count==1`: `count<=0`, `done<=1`, go to EXPIRED.
  - `start` is ignored in RUN.
- **EXPIRED:**
  - `count` holds 0.
  - `start`=1 and `rld!=0`: `count<=rld`, go to RUN.
  - `start`=1 and `rld==0`: `done<=1`, stay in EXPIRED.
- **Arithmetic:** all WIDTH-bit modulo. The decrement never wraps, because the block never decrements from 0.
- **Decodes:** `busy = (state==RUN)`; `zero = (count==0)`. Neither is an extra register stage.

## Timing
- `start` sampled at edge N with preset D≥1:
  - `busy` high after edge N.
  - First decrement at edge N+1.
  - `count==0` and `done==1` after edge N+D.
  - `busy` low after edge N+D.
- Each cycle with `pause`=1 in RUN delays expiry by one cycle.
- `done` width is exactly one clock. It never asserts in two consecutive cycles, except on repeated `start` in EXPIRED with `rld==0`: one pulse per start.
- **Reset mid-RUN:** outputs go to reset values immediately (asynchronous). The first edge after reset release sees state IDLE.
- **`load` during RUN:** the run is aborted without a `done` pulse and the count is replaced by the new preset.

## Configuration
- **`AUTO_RELOAD_EN` defined:**
  - In RUN with `pause`=0, `count==1` and `rld!=0`: `count<=rld`, `done<=1`, stay in RUN. This gives a periodic `done` every `rld` cycles.
  - With `rld==0` the behaviour is identical to the non-macro case.
  - EXPIRED is reachable only via `rld==0` or a zero preset.
- **`AUTO_RELOAD_EN` undefined:** one-shot behaviour exactly as in Operation.

## Test plan
- Reset low mid-run with count=5 -> `count=0`, `busy=0`, `done=0`, `zero=1` with no clock edge.
- `load` `data_in=3`, then `start` at edge N -> count reads 3,2,1,0 after edges N..N+3, `done` high only after N+3, `busy` low after N+3.
- Preset 4, start, `pause` high for 2 cycles mid-run -> `done` arrives 2 cycles later than unpaused (after N+6); count frozen while paused.
- `load` `data_in=0`, `start` -> `done` pulse after the next edge, state EXPIRED, `busy` never high. `load` and `start` asserted together -> `start` ignored, count equals `data_in`.
- `load` 9 (WIDTH=4), run to expiry, `start` again from EXPIRED -> count restarts at 9 and expires 9 cycles later. `load` 2 at mid-run -> no `done`, count=2, state IDLE.
- With `AUTO_RELOAD_EN`, preset 3, single `start` -> `done` after edges N+3, N+6, N+9, …; count sequence 3,2,1,3,2,1…; `busy` stays high.

Source files
------------

// File: rtl/load_4bit_down_timer.sv
//------------------------------------------------------------------------------
// Module      : load_4bit_down_timer
// Description : Loadable, pausable down-counting timer with start/done
//               handshake. A preset is loaded into both the count and a
//               reload register; start begins a run that decrements once per
//               clock and ends with a single-cycle done pulse.
//               Optional macro AUTO_RELOAD_EN: on expiry with a non-zero
//               reload value the count is reloaded and the run continues,
//               giving a periodic done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_4bit_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] rld;

  // Controller: load has priority over every state; done defaults low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= C_ZERO;
      rld   <= C_ZERO;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A start in the same cycle is deliberately dropped.
        count <= data_in;
        rld   <= data_in;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count != C_ZERO) begin
                state <= RUN;
              end else begin
                // Zero preset expires immediately without ever running.
                done  <= 1'b1;
                state <= EXPIRED;
              end
            end
          end
          RUN: begin
            if (!pause) begin
              if (count > C_ONE) begin
                count <= count - C_ONE;
              end else begin
                // RUN is only entered with a non-zero count, so this is count==1.
                done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                if (rld != C_ZERO) begin
                  count <= rld;
                end else begin
                  count <= C_ZERO;
                  state <= EXPIRED;
                end
`else
                count <= C_ZERO;
                state <= EXPIRED;
`endif
              end
            end
          end
          EXPIRED: begin
            count <= C_ZERO;
            if (start) begin
              if (rld != C_ZERO) begin
                count <= rld;
                state <= RUN;
              end else begin
                // One pulse per start when there is nothing to reload.
                done <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status decodes taken straight from the registers, no extra stage.
  always_comb begin
    busy = (state == RUN);
    zero = (count == C_ZERO);
  end

endmodule

`default_nettype wire
